gate_driver_deadtime: RTL and testbench

- Converts the hybrid controller's switching variable sigma into two complementary half-bridge gate commands: high-side and low-side.
- Enforces programmable dead time and minimum dwell time (chatter rejection) in clock cycles.
- Measures the half-period between consecutive commutations for monitoring and tuning theta.
- Sits between hybrid_control o_sigma and the FPGA pins driving the resonant converter's power stage.

---
 rtl/gate_driver_deadtime.sv | 143 ++++++++++++++
 tb/tb_gate_driver_deadtime.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_driver_deadtime.sv
// Complementary half-bridge gate driver with dead time, minimum dwell and half-period measurement.
// Gates are decoded from the next state and registered, so they only change on a state change.
module gate_driver_deadtime #(
  parameter int DEAD_TIME = 10,
  parameter int MIN_ON    = 50,
  parameter int CNT_W     = 16
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic             i_enable,
  input  logic             i_sigma,
  output logic             o_gate_H,
  output logic             o_gate_L,
  output logic [CNT_W-1:0] o_half_period,
  output logic             o_period_valid,
  output logic             o_fault
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] DT_H = 3'd1;
  localparam logic [2:0] ON_H = 3'd2;
  localparam logic [2:0] DT_L = 3'd3;
  localparam logic [2:0] ON_L = 3'd4;

  localparam logic [7:0]       DEAD_LAST = 8'(DEAD_TIME - 1);
  localparam logic [CNT_W-1:0] MIN_ON_C  = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic             sig_meta_reg, sig_s_reg;
  logic [2:0]       state_reg, state_next;
  logic [7:0]       dead_cnt_reg, dead_cnt_next;
  logic [CNT_W-1:0] dwell_cnt_reg, dwell_cnt_next, dwell_inc;
  logic [CNT_W-1:0] period_cnt_reg, period_cnt_next;
  logic             armed_reg, armed_next;
  logic [CNT_W-1:0] half_period_reg, half_period_next;
  logic             valid_reg, valid_next;
  logic             gate_h_reg, gate_l_reg, fault_reg;
  logic             on_entry;

  assign dwell_inc = (dwell_cnt_reg >= MIN_ON_C) ? MIN_ON_C : dwell_cnt_reg + 1'b1;

  always_comb begin
    state_next     = state_reg;
    dead_cnt_next  = dead_cnt_reg;
    dwell_cnt_next = dwell_cnt_reg;
    case (state_reg)
      IDLE: begin
        dead_cnt_next = '0;
        if (i_enable) state_next = sig_s_reg ? DT_H : DT_L;
      end
      DT_H, DT_L: begin
        // Target is fixed at entry; sig_s is not looked at during dead time.
        if (dead_cnt_reg == DEAD_LAST) begin
          state_next     = (state_reg == DT_H) ? ON_H : ON_L;
          dwell_cnt_next = '0;
        end else begin
          dead_cnt_next = dead_cnt_reg + 1'b1;
        end
      end
      ON_H: begin
        dwell_cnt_next = dwell_inc;
        if (!sig_s_reg && dwell_cnt_reg >= MIN_ON_C) begin
          state_next    = DT_L;
          dead_cnt_next = '0;
        end
      end
      ON_L: begin
        dwell_cnt_next = dwell_inc;
        if (sig_s_reg && dwell_cnt_reg >= MIN_ON_C) begin
          state_next    = DT_H;
          dead_cnt_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!i_enable) begin
      state_next     = IDLE;
      dead_cnt_next  = '0;
      dwell_cnt_next = '0;
    end
  end

  assign on_entry = ((state_next == ON_H) && (state_reg != ON_H)) ||
                    ((state_next == ON_L) && (state_reg != ON_L));

  always_comb begin
    period_cnt_next  = period_cnt_reg;
    armed_next       = armed_reg;
    half_period_next = half_period_reg;
    valid_next       = 1'b0;
    if (!i_enable) begin
      period_cnt_next = '0;
      armed_next      = 1'b0;
    end else if (on_entry) begin
      // First ON entry after IDLE only arms the measurement.
      if (armed_reg) begin
        half_period_next = period_cnt_reg;
        valid_next       = 1'b1;
      end
      period_cnt_next = CNT_W'(1);
      armed_next      = 1'b1;
    end else if (state_reg != IDLE && period_cnt_reg != CNT_MAX) begin
      period_cnt_next = period_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      sig_meta_reg    <= 1'b0;
      sig_s_reg       <= 1'b0;
      state_reg       <= IDLE;
      dead_cnt_reg    <= '0;
      dwell_cnt_reg   <= '0;
      period_cnt_reg  <= '0;
      armed_reg       <= 1'b0;
      half_period_reg <= '0;
      valid_reg       <= 1'b0;
      gate_h_reg      <= 1'b0;
      gate_l_reg      <= 1'b0;
      fault_reg       <= 1'b0;
    end else begin
      sig_meta_reg    <= i_sigma;
      sig_s_reg       <= sig_meta_reg;
      state_reg       <= state_next;
      dead_cnt_reg    <= dead_cnt_next;
      dwell_cnt_reg   <= dwell_cnt_next;
      period_cnt_reg  <= period_cnt_next;
      armed_reg       <= armed_next;
      half_period_reg <= half_period_next;
      valid_reg       <= valid_next;
      gate_h_reg      <= (state_next == ON_H);
      gate_l_reg      <= (state_next == ON_L);
      fault_reg       <= fault_reg | (gate_h_reg & gate_l_reg);
    end
  end

  assign o_gate_H       = gate_h_reg;
  assign o_gate_L       = gate_l_reg;
  assign o_half_period  = half_period_reg;
  assign o_period_valid = valid_reg;
  assign o_fault        = fault_reg;

endmodule

// File: tb/tb_gate_driver_deadtime.sv
// Directed bench for gate_driver_deadtime: dead time, dwell, disable, reset and period saturation.
module tb_gate_driver_deadtime;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        sigma;
  logic        gate_h, gate_l, period_valid, fault;
  logic [15:0] half_period;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  gate_driver_deadtime #(.DEAD_TIME(10), .MIN_ON(50), .CNT_W(16)) dut (
    .i_CLK(clk),
    .i_RESET(rst),
    .i_enable(enable),
    .i_sigma(sigma),
    .o_gate_H(gate_h),
    .o_gate_L(gate_l),
    .o_half_period(half_period),
    .o_period_valid(period_valid),
    .o_fault(fault)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; sigma = 1'b0;
    step(3);
    checks++;
    if ({gate_h, gate_l, period_valid, fault} !== 4'b0000 || half_period !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got h=%b l=%b v=%b f=%b hp=%0d, need all 0", gate_h, gate_l, period_valid, fault, half_period);
    end
    $display("test_reset done");
  endtask

  task automatic test_enable;
    rst = 1'b0; sigma = 1'b1;
    step(3);
    enable = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      checks++;
      if ({gate_h, gate_l, period_valid} !== 3'b000) begin
        errors++;
        $display("FAIL enable_deadtime cycle %0d: got h=%b l=%b v=%b, need 000", k, gate_h, gate_l, period_valid);
      end
    end
    step(1);
    checks++;
    if ({gate_h, gate_l, period_valid} !== 3'b100) begin
      errors++;
      $display("FAIL enable_first_on: got h=%b l=%b v=%b, need 100", gate_h, gate_l, period_valid);
    end
    $display("test_enable done");
  endtask

  task automatic test_square_wave;
    step(60);
    sigma = 1'b0;
    step(2);
    checks++;
    if (gate_h !== 1'b1) begin errors++; $display("FAIL sq_h_hold: got %b need 1", gate_h); end
    step(1);
    checks++;
    if ({gate_h, gate_l} !== 2'b00) begin errors++; $display("FAIL sq_h_fall: got %b%b need 00", gate_h, gate_l); end
    step(9);
    checks++;
    if (gate_l !== 1'b0) begin errors++; $display("FAIL sq_l_dead: got %b need 0", gate_l); end
    step(1);
    checks++;
    if ({gate_l, period_valid} !== 2'b11) begin errors++; $display("FAIL sq_l_rise: got l=%b v=%b need 11", gate_l, period_valid); end
    step(187);
    sigma = 1'b1;
    step(13);
    checks++;
    if ({gate_h, period_valid} !== 2'b11 || half_period !== 16'd200) begin
      errors++;
      $display("FAIL sq_h_entry: got h=%b v=%b hp=%0d need 1 1 200", gate_h, period_valid, half_period);
    end
    step(1);
    checks++;
    if (period_valid !== 1'b0) begin errors++; $display("FAIL sq_strobe_width: got %b need 0", period_valid); end
    step(186);
    sigma = 1'b0;
    step(13);
    checks++;
    if ({gate_l, period_valid} !== 2'b11 || half_period !== 16'd200) begin
      errors++;
      $display("FAIL sq_l_entry: got l=%b v=%b hp=%0d need 1 1 200", gate_l, period_valid, half_period);
    end
    $display("test_square_wave done");
  endtask

  task automatic test_chatter;
    step(100);
    sigma = 1'b1;
    step(13);
    checks++;
    if ({gate_h, period_valid} !== 2'b11 || half_period !== 16'd113) begin
      errors++;
      $display("FAIL chat_h_entry: got h=%b v=%b hp=%0d need 1 1 113", gate_h, period_valid, half_period);
    end
    step(5);
    sigma = 1'b0;
    step(1);
    sigma = 1'b1;
    step(4);
    checks++;
    if ({gate_h, gate_l} !== 2'b10) begin errors++; $display("FAIL chat_glitch: got %b%b need 10", gate_h, gate_l); end
    step(10);
    sigma = 1'b0;
    step(30);
    checks++;
    if (gate_h !== 1'b1) begin errors++; $display("FAIL chat_min_on_hold: got %b need 1", gate_h); end
    step(1);
    checks++;
    if (gate_h !== 1'b0) begin errors++; $display("FAIL chat_min_on_release: got %b need 0", gate_h); end
    step(9);
    checks++;
    if (gate_l !== 1'b0) begin errors++; $display("FAIL chat_l_dead: got %b need 0", gate_l); end
    step(1);
    checks++;
    if ({gate_l, period_valid} !== 2'b11 || half_period !== 16'd61) begin
      errors++;
      $display("FAIL chat_l_entry: got l=%b v=%b hp=%0d need 1 1 61", gate_l, period_valid, half_period);
    end
    $display("test_chatter done");
  endtask

  task automatic test_disable;
    step(60);
    sigma = 1'b1;
    step(13);
    checks++;
    if ({gate_h, period_valid} !== 2'b11 || half_period !== 16'd73) begin
      errors++;
      $display("FAIL dis_h_entry: got h=%b v=%b hp=%0d need 1 1 73", gate_h, period_valid, half_period);
    end
    step(60);
    sigma = 1'b0;
    step(5);
    enable = 1'b0;
    step(1);
    checks++;
    if ({gate_h, gate_l, period_valid} !== 3'b000) begin
      errors++;
      $display("FAIL dis_gates_off: got h=%b l=%b v=%b need 000", gate_h, gate_l, period_valid);
    end
    step(5);
    enable = 1'b1;
    step(10);
    checks++;
    if (gate_l !== 1'b0) begin errors++; $display("FAIL dis_reen_dead: got %b need 0", gate_l); end
    step(1);
    checks++;
    if ({gate_l, period_valid} !== 2'b10) begin
      errors++;
      $display("FAIL dis_reen_no_strobe: got l=%b v=%b need 1 0", gate_l, period_valid);
    end
    $display("test_disable done");
  endtask

  task automatic test_reset_mid_on_l;
    step(20);
    checks++;
    if (half_period !== 16'd73) begin errors++; $display("FAIL rst_pre_hp: got %0d need 73", half_period); end
    rst = 1'b1;
    step(1);
    checks++;
    if ({gate_h, gate_l, period_valid, fault} !== 4'b0000 || half_period !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_on_l: got h=%b l=%b v=%b f=%b hp=%0d need all 0", gate_h, gate_l, period_valid, fault, half_period);
    end
    rst = 1'b0;
    step(10);
    checks++;
    if (gate_l !== 1'b0) begin errors++; $display("FAIL rst_restart_dead: got %b need 0", gate_l); end
    step(1);
    checks++;
    if ({gate_l, period_valid} !== 2'b10) begin
      errors++;
      $display("FAIL rst_restart_arm: got l=%b v=%b need 1 0", gate_l, period_valid);
    end
    $display("test_reset_mid_on_l done");
  endtask

  task automatic test_saturation;
    bit seen;
    seen = 1'b0;
    step(70000);
    sigma = 1'b1;
    for (int k = 0; k < 40 && !seen; k++) begin
      step(1);
      if (period_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || half_period !== 16'hFFFF || gate_h !== 1'b1) begin
      errors++;
      $display("FAIL sat_period: got seen=%b hp=%0d h=%b need 1 65535 1", seen, half_period, gate_h);
    end
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL no_fault: got %b need 0", fault); end
    $display("test_saturation done");
  endtask

  initial begin
    test_reset();
    test_enable();
    test_square_wave();
    test_chatter();
    test_disable();
    test_reset_mid_on_l();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
